// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the CDB arbiter slice: data/tag widths,
// the invalid ROB tag, boolean helpers and the round-robin grant encoding.
package cdb_arbiter_pkg;

  localparam int CDB_DATA_W     = 32;
  localparam int CDB_ROB_ID_W   = 5;
  localparam int CDB_FIFO_DEPTH = 4;
  localparam int INVALID_ROB    = 0;
  localparam int NULL           = 0;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Source index doubles as the grant encoding: RS_EX = 0, LS_EX = 1.
  typedef enum logic {
    GRANT_RS = 1'b0,
    GRANT_LS = 1'b1
  } grant_e;

endpackage

// File: rtl/cdb_fifo.sv
// Per-source result buffer {rob_id, data}. Head is read combinationally so the
// arbiter can broadcast it in the same cycle; flush empties it on rollback.
module cdb_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DATA_W   = CDB_DATA_W,
  parameter int ROB_ID_W = CDB_ROB_ID_W,
  parameter int DEPTH    = CDB_FIFO_DEPTH,
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                flush,
  input  logic                push,
  input  logic [ROB_ID_W-1:0] push_rob_id,
  input  logic [DATA_W-1:0]   push_data,
  input  logic                pop,
  output logic [ROB_ID_W-1:0] head_rob_id,
  output logic [DATA_W-1:0]   head_data,
  output logic [PTR_W:0]      count,
  output logic                full
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);

  logic [ROB_ID_W+DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]           wr_ptr_reg;
  logic [PTR_W-1:0]           rd_ptr_reg;
  logic [PTR_W:0]             count_reg;
  logic                       do_push;
  logic                       do_pop;

  // A push into a full buffer is dropped outright, even if a pop happens too.
  assign full    = (count_reg == (PTR_W + 1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count_reg != '0);
  assign count   = count_reg;
  assign {head_rob_id, head_data} = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (rdy) begin
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
        if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        case ({do_push, do_pop})
          2'b10:   count_reg <= count_reg + CNT_ONE;
          2'b01:   count_reg <= count_reg - CNT_ONE;
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && rdy && !flush && do_push) mem[wr_ptr_reg] <= {push_rob_id, push_data};
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin sharing of the common data bus between the ALU and load/store
// units, with a small per-source buffer and a registered broadcast.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int DATA_W     = CDB_DATA_W,
  parameter int ROB_ID_W   = CDB_ROB_ID_W,
  parameter int FIFO_DEPTH = CDB_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                valid_sign_from_rs_ex,
  input  logic [ROB_ID_W-1:0] rob_id_from_rs_ex,
  input  logic [DATA_W-1:0]   data_from_rs_ex,
  input  logic                valid_sign_from_ls_ex,
  input  logic [ROB_ID_W-1:0] rob_id_from_ls_ex,
  input  logic [DATA_W-1:0]   data_from_ls_ex,
  input  logic                rollback_sign_from_rob,
  output logic                full_sign_to_rs_ex,
  output logic                full_sign_to_ls_ex,
  output logic                valid_sign_to_cdb,
  output logic [ROB_ID_W-1:0] rob_id_to_cdb,
  output logic [DATA_W-1:0]   data_to_cdb
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ROB_ID_W-1:0] INV_TAG = ROB_ID_W'(INVALID_ROB);

  logic                in_valid  [2];
  logic [ROB_ID_W-1:0] in_rob    [2];
  logic [DATA_W-1:0]   in_data   [2];
  logic [ROB_ID_W-1:0] head_rob  [2];
  logic [DATA_W-1:0]   head_data [2];
  logic [PTR_W:0]      fifo_count[2];
  logic                fifo_full [2];
  logic                fifo_empty[2];
  logic                cand      [2];
  logic [ROB_ID_W-1:0] cand_rob  [2];
  logic [DATA_W-1:0]   cand_data [2];
  logic                grant_hit [2];
  logic                src_push  [2];
  logic                src_pop   [2];

  grant_e              grant_sel;
  grant_e              last_grant_reg;
  logic                contested;
  logic                any_cand;
  logic [ROB_ID_W-1:0] sel_rob;
  logic [DATA_W-1:0]   sel_data;
  logic                valid_reg;
  logic [ROB_ID_W-1:0] rob_id_reg;
  logic [DATA_W-1:0]   data_reg;

  assign in_valid[0] = valid_sign_from_rs_ex && (rob_id_from_rs_ex != INV_TAG);
  assign in_valid[1] = valid_sign_from_ls_ex && (rob_id_from_ls_ex != INV_TAG);
  assign in_rob[0]   = rob_id_from_rs_ex;
  assign in_rob[1]   = rob_id_from_ls_ex;
  assign in_data[0]  = data_from_rs_ex;
  assign in_data[1]  = data_from_ls_ex;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      // Buffered results always go first so per-source order is preserved.
      assign fifo_empty[gi] = (fifo_count[gi] == '0);
      assign cand[gi]       = !fifo_empty[gi] || in_valid[gi];
      assign cand_rob[gi]   = fifo_empty[gi] ? in_rob[gi]  : head_rob[gi];
      assign cand_data[gi]  = fifo_empty[gi] ? in_data[gi] : head_data[gi];
      assign grant_hit[gi]  = cand[gi] && (grant_sel == ((gi == 0) ? GRANT_RS : GRANT_LS));
      assign src_pop[gi]    = grant_hit[gi] && !fifo_empty[gi];
      assign src_push[gi]   = in_valid[gi] && !(grant_hit[gi] && fifo_empty[gi]);

      cdb_fifo #(
        .DATA_W  (DATA_W),
        .ROB_ID_W(ROB_ID_W),
        .DEPTH   (FIFO_DEPTH)
      ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .flush      (rollback_sign_from_rob),
        .push       (src_push[gi]),
        .push_rob_id(in_rob[gi]),
        .push_data  (in_data[gi]),
        .pop        (src_pop[gi]),
        .head_rob_id(head_rob[gi]),
        .head_data  (head_data[gi]),
        .count      (fifo_count[gi]),
        .full       (fifo_full[gi])
      );
    end
  endgenerate

  always_comb begin
    contested = cand[0] && cand[1];
    any_cand  = cand[0] || cand[1];
    grant_sel = GRANT_RS;
    if (contested)    grant_sel = (last_grant_reg == GRANT_LS) ? GRANT_RS : GRANT_LS;
    else if (cand[1]) grant_sel = GRANT_LS;
    sel_rob  = (grant_sel == GRANT_LS) ? cand_rob[1]  : cand_rob[0];
    sel_data = (grant_sel == GRANT_LS) ? cand_data[1] : cand_data[0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_reg      <= FALSE;
      rob_id_reg     <= INV_TAG;
      data_reg       <= '0;
      last_grant_reg <= GRANT_LS;
    end else if (rdy) begin
      if (rollback_sign_from_rob) begin
        valid_reg      <= FALSE;
        rob_id_reg     <= INV_TAG;
        data_reg       <= '0;
        last_grant_reg <= GRANT_LS;
      end else begin
        // The round-robin pointer only moves when both sources compete.
        if (contested) last_grant_reg <= grant_sel;
        valid_reg  <= any_cand;
        rob_id_reg <= any_cand ? sel_rob  : INV_TAG;
        data_reg   <= any_cand ? sel_data : '0;
      end
    end
  end

  assign valid_sign_to_cdb  = valid_reg;
  assign rob_id_to_cdb      = rob_id_reg;
  assign data_to_cdb        = data_reg;
  assign full_sign_to_rs_ex = fifo_full[0];
  assign full_sign_to_ls_ex = fifo_full[1];

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed stimulus pushes expected
// broadcasts into a queue, an independent monitor pops them as the CDB fires.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        valid_sign_from_rs_ex = 1'b0;
  logic [4:0]  rob_id_from_rs_ex = '0;
  logic [31:0] data_from_rs_ex = '0;
  logic        valid_sign_from_ls_ex = 1'b0;
  logic [4:0]  rob_id_from_ls_ex = '0;
  logic [31:0] data_from_ls_ex = '0;
  logic        rollback_sign_from_rob = 1'b0;
  logic        full_sign_to_rs_ex;
  logic        full_sign_to_ls_ex;
  logic        valid_sign_to_cdb;
  logic [4:0]  rob_id_to_cdb;
  logic [31:0] data_to_cdb;

  typedef struct {
    logic [4:0]  rob;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic rst_q = 1'b0;
  logic rdy_q = 1'b0;

  always #5 clk = ~clk;

  cdb_arbiter dut (
    .clk                   (clk),
    .rst                   (rst),
    .rdy                   (rdy),
    .valid_sign_from_rs_ex (valid_sign_from_rs_ex),
    .rob_id_from_rs_ex     (rob_id_from_rs_ex),
    .data_from_rs_ex       (data_from_rs_ex),
    .valid_sign_from_ls_ex (valid_sign_from_ls_ex),
    .rob_id_from_ls_ex     (rob_id_from_ls_ex),
    .data_from_ls_ex       (data_from_ls_ex),
    .rollback_sign_from_rob(rollback_sign_from_rob),
    .full_sign_to_rs_ex    (full_sign_to_rs_ex),
    .full_sign_to_ls_ex    (full_sign_to_ls_ex),
    .valid_sign_to_cdb     (valid_sign_to_cdb),
    .rob_id_to_cdb         (rob_id_to_cdb),
    .data_to_cdb           (data_to_cdb)
  );

  // Remember whether the last edge was a live update (not reset, not stalled).
  always @(posedge clk) begin
    rst_q <= rst;
    rdy_q <= rdy;
  end

  always @(negedge clk) begin
    if (rst_q && rdy_q && valid_sign_to_cdb) begin
      exp_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL cdb_unexpected: got rob %0d data %0h, required no broadcast", rob_id_to_cdb, data_to_cdb);
      end else begin
        e = exp_q.pop_front();
        if (rob_id_to_cdb !== e.rob || data_to_cdb !== e.data) begin
          n_fail++;
          $display("FAIL cdb_order: got rob %0d data %0h, required rob %0d data %0h",
                   rob_id_to_cdb, data_to_cdb, e.rob, e.data);
        end else begin
          $display("cdb broadcast rob %0d data %0h ok", rob_id_to_cdb, data_to_cdb);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic drive(input logic rv, input logic [4:0] rid, input logic lv, input logic [4:0] lid);
    valid_sign_from_rs_ex = rv;
    rob_id_from_rs_ex     = rid;
    data_from_rs_ex       = 32'h1000 + 32'(rid);
    valid_sign_from_ls_ex = lv;
    rob_id_from_ls_ex     = lid;
    data_from_ls_ex       = 32'h2000 + 32'(lid);
  endtask

  task automatic exp_rs(input logic [4:0] rob);
    exp_q.push_back('{rob: rob, data: 32'h1000 + 32'(rob)});
  endtask

  task automatic exp_ls(input logic [4:0] rob);
    exp_q.push_back('{rob: rob, data: 32'h2000 + 32'(rob)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      valid_sign_from_rs_ex  = 1'($urandom);
      rob_id_from_rs_ex      = 5'($urandom);
      data_from_rs_ex        = $urandom;
      valid_sign_from_ls_ex  = 1'($urandom);
      rob_id_from_ls_ex      = 5'($urandom);
      data_from_ls_ex        = $urandom;
      rollback_sign_from_rob = 1'($urandom);
      step();
    end
    check("reset_valid", valid_sign_to_cdb, 0);
    check("reset_rob", rob_id_to_cdb, 0);
    check("reset_data", data_to_cdb, 0);
    check("reset_full_rs", full_sign_to_rs_ex, 0);
    check("reset_full_ls", full_sign_to_ls_ex, 0);
    rollback_sign_from_rob = 1'b0;
    drive(0, 0, 0, 0);
    rst = 1'b1;
    step();
    check("idle_valid_0", valid_sign_to_cdb, 0);
    drive(1, 0, 0, 0);
    step();
    check("invalid_tag_ignored", valid_sign_to_cdb, 0);

    // Single source, one-cycle latency
    drive(1, 3, 0, 0);
    data_from_rs_ex = 32'h11;
    exp_q.push_back('{rob: 5'd3, data: 32'h11});
    step();
    check("single_valid", valid_sign_to_cdb, 1);
    check("single_rob", rob_id_to_cdb, 3);
    check("single_data", data_to_cdb, 32'h11);
    drive(0, 0, 0, 0);
    step();
    check("single_valid_drop", valid_sign_to_cdb, 0);

    // Contention: RS 1..8, LS 9..15, alternating grants starting with RS
    for (int i = 1; i <= 7; i++) begin
      exp_rs(5'(i));
      exp_ls(5'(i + 8));
    end
    exp_rs(5'd8);
    for (int i = 1; i <= 7; i++) begin
      drive(1, 5'(i), 1, 5'(i + 8));
      step();
      if (i < 7) check("ls_full_early", full_sign_to_ls_ex, 0);
    end
    check("ls_full_at_4", full_sign_to_ls_ex, 1);
    check("rs_not_full", full_sign_to_rs_ex, 0);
    drive(1, 8, 0, 0);
    step();
    check("ls_full_released", full_sign_to_ls_ex, 0);
    check("rs_full_at_4", full_sign_to_rs_ex, 1);
    drive(0, 0, 0, 0);
    step();
    check("rs_full_released", full_sign_to_rs_ex, 0);
    for (int i = 0; i < 6; i++) step();
    check("drain_last_rob", rob_id_to_cdb, 8);
    step();
    check("drain_idle", valid_sign_to_cdb, 0);

    // Rollback with two entries in each buffer and RS as last winner
    exp_rs(16); exp_ls(20); exp_rs(17); exp_ls(21); exp_rs(18);
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'(16 + i), 1, 5'(20 + i));
      step();
    end
    drive(1, 28, 0, 0);
    step();
    rollback_sign_from_rob = 1'b1;
    drive(1, 24, 1, 25);
    step();
    rollback_sign_from_rob = 1'b0;
    check("rollback_valid", valid_sign_to_cdb, 0);
    check("rollback_rob", rob_id_to_cdb, 0);
    drive(0, 0, 0, 0);
    step();
    check("rollback_empty", valid_sign_to_cdb, 0);
    exp_rs(26); exp_ls(27);
    drive(1, 26, 1, 27);
    step();
    check("post_rollback_rs_first", rob_id_to_cdb, 26);
    drive(0, 0, 0, 0);
    step();

    // rdy stall with one entry buffered per source
    exp_ls(5); exp_rs(4); exp_ls(7); exp_rs(6);
    drive(1, 4, 1, 5);
    step();
    drive(1, 6, 1, 7);
    step();
    rdy = 1'b0;
    drive(1, 8, 1, 8);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid_hold", valid_sign_to_cdb, 1);
      check("stall_rob_hold", rob_id_to_cdb, 4);
    end
    rdy = 1'b1;
    drive(0, 0, 0, 0);
    step();
    check("resume_ls", rob_id_to_cdb, 7);
    step();
    check("resume_rs", rob_id_to_cdb, 6);
    step();
    check("resume_idle", valid_sign_to_cdb, 0);
    step();

    check("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the single common data bus (CDB) between the two execution units, the ALU path (RS_EX) and the load/store path (LS_EX). Both units complete at most one result per cycle, but the CDB carries only one. Each source therefore gets a small per-source buffer, and a round-robin arbiter grants one result per cycle onto a registered broadcast. RS, LSB and ROB consume that broadcast in place of the raw per-unit result buses.

## Interface
Parameters:
- DATA_W, 32, result data width
- ROB_ID_W, 5, ROB tag width; tag 0 is `INVALID_ROB`
- FIFO_DEPTH, 4, entries per source buffer; power of two, ≥ 2

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-low; sampled on rising clk, 0 = reset
- rdy  in  1  global ready; 0 freezes all state and outputs
- valid_sign_from_rs_ex  in  1  ALU result valid this cycle
- rob_id_from_rs_ex  in  ROB_ID_W  ALU result tag
- data_from_rs_ex  in  DATA_W  ALU result value
- valid_sign_from_ls_ex  in  1  load/store result valid this cycle
- rob_id_from_ls_ex  in  ROB_ID_W  load/store result tag
- data_from_ls_ex  in  DATA_W  load/store result value
- rollback_sign_from_rob  in  1  misprediction flush
- full_sign_to_rs_ex  out  1  ALU buffer full; ALU must not present a result
- full_sign_to_ls_ex  out  1  LS buffer full; LS must not present a result
- valid_sign_to_cdb  out  1  broadcast valid (registered)
- rob_id_to_cdb  out  ROB_ID_W  broadcast tag (registered)
- data_to_cdb  out  DATA_W  broadcast value (registered)

## Operation
- A source result counts as valid only when its valid is 1 and its rob_id ≠ `INVALID_ROB`.
- Each source has a candidate each cycle:
  - if its FIFO is non-empty, the candidate is the FIFO head;
  - otherwise the candidate is the incoming result (bypass).
- Arbitration:
  - If exactly one source has a candidate, that source is granted.
  - If both have candidates, the source opposite to `last_grant` is granted, and `last_grant` updates to the winner.
  - `last_grant` changes only on contested cycles.
  - `last_grant` resets to LS, so RS_EX wins the first contest.
- On each edge:
  - The granted candidate is loaded into the output register with valid = 1.
  - If there is no candidate, the output register takes valid = 0, rob_id = `INVALID_ROB` and data = 0.
  - A granted FIFO head is popped.
  - A valid incoming result that is not consumed via bypass is pushed into its source FIFO.
  - Push and pop of the same FIFO may occur in the same cycle.
- Within each source, results leave in arrival order. Order across sources is unspecified beyond the round-robin rule.
- `full_sign_to_*` = (count == FIFO_DEPTH), driven from registered count (no combinational path from inputs).
- A valid input while its FIFO is full is a protocol violation. The result is dropped and no state changes for that source.
- Rollback (when rdy = 1):
  - Both FIFOs are emptied and same-cycle inputs are discarded.
  - The output register is cleared to valid = 0.
  - `last_grant` returns to LS.
- rdy = 0: inputs are ignored, no push, pop or grant, outputs hold, and rollback is not acted on.

## Timing
- Reset values: valid_sign_to_cdb = 0, rob_id_to_cdb = `INVALID_ROB`, data_to_cdb = 0, both full signals = 0, both FIFO counts = 0, `last_grant` = LS.
- Uncontended latency: a result presented in cycle t is broadcast in cycle t+1.
- A losing bypass candidate is enqueued at edge t and broadcast no earlier than t+2.
- Sustained contention: grants alternate RS, LS, RS, LS, giving each source one slot in two, so throughput is 1 result per cycle total.
- Full asserts in the cycle after the push that fills the FIFO. It deasserts in the cycle after a pop from a full FIFO, unless a push occurred in the same cycle.
- Reset has priority over rollback; rollback has priority over normal operation. Reset mid-stream discards all buffered results.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. The count is log2(FIFO_DEPTH)+1 bits.

## Structure
- Shared defines header: `DATA_TYPE`, `ROB_ID_TYPE`, `INVALID_ROB`, `TRUE`/`FALSE`, `NULL`. Add `CDB_FIFO_DEPTH` there.
- One sub-module, `cdb_fifo`: a synchronous FIFO {rob_id, data} with push, pop, flush, head, count and full. It has the same clk, rst and rdy semantics and is instantiated twice.
- `cdb_arbiter` holds the candidate select, the round-robin bit and the output register.

## Test plan
- Reset: hold rst = 0 for 2 cycles with random inputs -> all outputs at reset values; release rst -> valid_sign_to_cdb stays 0 with no inputs.
- Single source: RS_EX presents (rob 3, 0x11) at t -> CDB shows valid, rob 3, 0x11 at t+1 and valid = 0 at t+2.
- Contention: both sources present every cycle for 6 cycles (RS rob 1..6, LS rob 9..14) -> CDB order 1, 9, 2, 10, 3, 11, …; LS full asserts once its FIFO reaches 4; no result lost or reordered within a source.
- Back-pressure: continue the contention stream while respecting full -> no drop; full deasserts one cycle after the draining pop.
- Rollback: with both FIFOs holding 2 entries, pulse rollback with new inputs present -> next cycle valid = 0, both counts = 0, inputs discarded; a fresh RS input afterwards wins the first contest.
- rdy stall: with entries buffered, drive rdy = 0 for 3 cycles -> outputs and counts frozen; resume -> the broadcast sequence continues unchanged.
